uart_tx: RTL
============

Name: uart_tx

Overview:
Serial UART transmitter, the transmit counterpart of the team's uart_rx.
- Accepts one parallel word per handshake and serialises it LSB-first: start bit, DATA_WD data bits, optional parity, then STOP_BITS stop bits.
- Bit timing comes from the shared baud-tick pulse; each bit lasts exactly OVERSAMPLING_RATE ticks, so it matches the receiver's framing and parity conventions.

Parameters:
DATA_WD, 8, data bits per frame (5..9)
OVERSAMPLING_RATE, 16, tick pulses per serial bit (power of 2, >=4)
PARITY, 1, 2-bit code: 1 = odd, 2 = even, 0/3 = no parity bit
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset (sampled on rising clk)
tick  input  1  one-clk pulse from baud generator, OVERSAMPLING_RATE per bit
tx_start  input  1  request to send din; honoured only in IDLE
din  input  DATA_WD  parallel data, captured on the accepting edge
tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress; no new request accepted
tx_done  output  1  one-clk pulse, frame fully sent

Behaviour:
- Reset (rst==0 at posedge clk): state IDLE, tx=1, tx_busy=0, tx_done=0, tick_count=0, bit_index=0, shift register 0. Reset overrides everything, including mid-frame: tx returns to 1 on that edge and the partial frame is abandoned.
- States, one-hot: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - tx=1, tx_busy=0.
  - If tx_start=1: on the same edge latch din into the shift register, compute the parity bit from din, clear tick_count and bit_index, set tx_busy=1, and go to START.
  - tx_start while not IDLE is ignored; there is no queueing.
- tx is registered. It takes the new state's bit value on the edge the state is entered: START gives 0, DATA gives shreg[0], PARITY gives the parity bit, STOP and DONE give 1.
- Bit period:
  - tick_count increments only on tick while in START, DATA, PARITY or STOP.
  - On tick with tick_count==OVERSAMPLING_RATE-1, tick_count wraps to 0 and the bit ends.
  - Clocks without a tick hold all state.
- START: at bit end go to DATA.
- DATA:
  - At each bit end, shift the register right and increment bit_index.
  - After bit_index reaches DATA_WD-1 and that bit ends, go to PARITY if parity is enabled, else STOP.
  - bit_index width is clog2(DATA_WD+1).
- Parity value:
  - Odd: ~^data, so the total count of ones in data+parity is odd.
  - Even: ^data.
- PARITY: one bit period, then STOP.
- STOP:
  - Lasts STOP_BITS bit periods; a separate stop counter is cleared on entry.
  - At the final bit end go to DONE.
- DONE:
  - Exactly one clk. tx_done=1, tx=1, tx_busy stays 1.
  - Next edge goes to IDLE, clearing tx_busy and tx_done.
  - tx_start asserted during DONE is ignored.
- tx_busy is high from the edge after acceptance through the DONE cycle inclusive.
- Frame length in ticks: OVERSAMPLING_RATE*(1+DATA_WD+P+STOP_BITS), where P is 1 if parity is enabled, else 0.
- Back-to-back: the earliest re-accept is the first IDLE cycle after DONE, which adds one idle-high clk between frames.
- A tick coinciding with acceptance in IDLE is not counted.
- Illegal or unreachable state encodings go to IDLE with reset output values.

Decomposition:
- Shared package uart_pkg holds:
  - One-hot state localparams (IDLE..DONE), shared with uart_rx.
  - Parity codes PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - A parity function par_bit(data, code).
- No sub-module inside uart_tx. The baud tick comes from the existing shared baud generator instantiated at the top level.

Test Plan:
1. Defaults, tick tied high, din=8'hA5, one-clk tx_start → tx: 0 for 16 clk; bits 1,0,1,0,0,1,0,1 at 16 clk each; parity 1 (odd; A5 has four ones); stop 1. tx_done pulses at clk 176 after the START edge. Loopback into uart_rx gives dout=8'hA5 with no error flags.
2. PARITY=2, din=8'h07 → parity bit 1. PARITY=0, same din → no parity slot, frame is 160 clk, tx_done at 160.
3. STOP_BITS=2, tick every 4th clk, din=8'h00 → stop high for 128 clk. Total frame is 4*16*12=768 clk, with tx low across start and data.
4. tx_start pulsed at bit 3 of a frame with a different din → ignored; line shows only the first frame. A request in the first IDLE cycle after tx_done is accepted, with a 1-clk idle gap.
5. rst=0 for one clk mid-DATA → on that edge tx=1, tx_busy=0 and no tx_done. A new frame after reset transmits correctly.
6. tick held low for 50 clk inside a bit → tx and all counters frozen; the bit completes after the remaining ticks arrive.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot frame states, parity codes and the parity helper.
// Used by both uart_tx and uart_rx so that the two ends agree on framing.
package uart_pkg;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_PARITY = 6'b001000,
    ST_STOP   = 6'b010000,
    ST_DONE   = 6'b100000
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam int MAX_DATA_WD = 9;

  // Narrower words are zero-extended by the caller; the extra zeros do not change the XOR.
  function automatic logic par_bit(input logic [MAX_DATA_WD-1:0] data, input logic [1:0] code);
    case (code)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Each serial bit spans OVERSAMPLING_RATE baud ticks; tx is driven from a register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WD           = 8,
  parameter int OVERSAMPLING_RATE = 16,
  parameter int PARITY            = 1,
  parameter int STOP_BITS         = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               tx_start,
  input  logic [DATA_WD-1:0] din,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int TW = $clog2(OVERSAMPLING_RATE);
  localparam int BW = $clog2(DATA_WD + 1);
  localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);

  state_t             state, state_n;
  logic [TW-1:0]      tick_count, tick_count_n;
  logic [BW-1:0]      bit_index, bit_index_n;
  logic [DATA_WD-1:0] shreg, shreg_n;
  logic               par_r, par_n;
  logic [1:0]         stop_count, stop_count_n;
  logic               tx_n, tx_busy_n, tx_done_n;
  logic               bit_end;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tick_count <= '0;
      bit_index  <= '0;
      shreg      <= '0;
      par_r      <= 1'b0;
      stop_count <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      tick_count <= tick_count_n;
      bit_index  <= bit_index_n;
      shreg      <= shreg_n;
      par_r      <= par_n;
      stop_count <= stop_count_n;
      tx         <= tx_n;
      tx_busy    <= tx_busy_n;
      tx_done    <= tx_done_n;
    end
  end

  assign bit_end = tick && (tick_count == TW'(OVERSAMPLING_RATE - 1));

  // tx_n is the line value for the state being entered, so tx changes on the entry edge.
  always_comb begin
    state_n      = state;
    tick_count_n = tick_count;
    bit_index_n  = bit_index;
    shreg_n      = shreg;
    par_n        = par_r;
    stop_count_n = stop_count;
    tx_n         = tx;
    tx_busy_n    = tx_busy;
    tx_done_n    = 1'b0;

    if (tick && (state == ST_START || state == ST_DATA ||
                 state == ST_PARITY || state == ST_STOP)) begin
      tick_count_n = bit_end ? '0 : tick_count + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        tx_n      = 1'b1;
        tx_busy_n = 1'b0;
        if (tx_start) begin
          shreg_n      = din;
          par_n        = par_bit(MAX_DATA_WD'(din), 2'(PARITY));
          tick_count_n = '0;
          bit_index_n  = '0;
          tx_busy_n    = 1'b1;
          tx_n         = 1'b0;
          state_n      = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          tx_n    = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_n     = shreg >> 1;
          bit_index_n = bit_index + 1'b1;
          if (bit_index == BW'(DATA_WD - 1)) begin
            if (PAR_EN) begin
              state_n = ST_PARITY;
              tx_n    = par_r;
            end else begin
              state_n      = ST_STOP;
              stop_count_n = '0;
              tx_n         = 1'b1;
            end
          end else begin
            tx_n = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n      = ST_STOP;
          stop_count_n = '0;
          tx_n         = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_count == 2'(STOP_BITS - 1)) begin
            state_n   = ST_DONE;
            tx_done_n = 1'b1;
          end else begin
            stop_count_n = stop_count + 1'b1;
          end
          tx_n = 1'b1;
        end
      end
      ST_DONE: begin
        state_n   = ST_IDLE;
        tx_n      = 1'b1;
        tx_busy_n = 1'b0;
      end
      default: begin
        state_n      = ST_IDLE;
        tick_count_n = '0;
        bit_index_n  = '0;
        stop_count_n = '0;
        tx_n         = 1'b1;
        tx_busy_n    = 1'b0;
      end
    endcase
  end

endmodule
